pw_mem_responder: RTL and testbench

Memory-side responder for the page-walker (PW) PTE-read interface. It accepts 8-byte PTE read requests from `NUM_PW` page walkers and arbitrates them round-robin onto one in-order memory read port. It tracks outstanding reads in a FIFO and returns each response to the originating walker, tagged with the walker index. Responses whose request generation no longer matches the live generation are discarded, so walkers never see stale PTEs after a flush.

---
 rtl/pw_mem_responder.sv | 146 ++++++++++++++
 tb/tb_pw_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_mem_responder.sv
// Page-walker PTE-read responder: round-robin arbitration onto one in-order memory
// read port, with an outstanding-read FIFO that routes and generation-filters responses.
module pw_mem_responder #(
    parameter int NUM_PW  = 2,
    parameter int PADDR_W = 56,
    parameter int DEPTH   = 4,
    localparam int ID_W   = (NUM_PW > 1) ? $clog2(NUM_PW) : 1,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_PW-1:0]   req_valid,
    input  logic [PADDR_W-1:0]  req_paddr      [NUM_PW],
    input  logic [31:0]         req_generation [NUM_PW],
    output logic [NUM_PW-1:0]   req_accepted,
    output logic                noroom,
    output logic                res_valid,
    output logic [ID_W-1:0]     res_id,
    output logic [63:0]         res_data,
    output logic                res_error,
    input  logic [31:0]         generation,
    output logic                mem_req_valid,
    output logic [PADDR_W-1:0]  mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_res_valid,
    input  logic [63:0]         mem_res_data,
    input  logic                mem_res_error,
    output logic                protocol_err
);

    logic [ID_W-1:0]  rr_q, rr_d;
    logic [ID_W-1:0]  winner;
    logic             accept;
    logic             pop;
    logic             stray;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ID_W-1:0]  fifo_id_q  [DEPTH];
    logic [31:0]      fifo_gen_q [DEPTH];

    logic             res_valid_q;
    logic [ID_W-1:0]  res_id_q;
    logic [63:0]      res_data_q;
    logic             res_error_q;
    logic             protocol_err_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after rr_q, wrapping modulo NUM_PW.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = rr_q;
        for (int k = 0; k < NUM_PW; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_PW) begin
                idx = idx - NUM_PW;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign noroom        = (count_q == CNT_W'(DEPTH));
    assign mem_req_valid = (|req_valid) && !noroom;
    assign mem_req_addr  = req_paddr[winner] & ~PADDR_W'(7);
    assign accept        = mem_req_valid && mem_req_ready;

    for (genvar gi = 0; gi < NUM_PW; gi++) begin : g_accept
        assign req_accepted[gi] = accept && (winner == ID_W'(gi));
    end

    // Responses with nothing outstanding are never popped; they only flag an error.
    assign pop   = mem_res_valid && (count_q != '0);
    assign stray = mem_res_valid && (count_q == '0);

    always_comb begin
        rr_d    = rr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
        if (accept) begin
            rr_d = (winner == ID_W'(NUM_PW - 1)) ? '0 : winner + 1'b1;
            wr_d = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (accept) begin
            fifo_id_q[wr_q]  <= winner;
            fifo_gen_q[wr_q] <= req_generation[winner];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_valid_q    <= 1'b0;
            res_id_q       <= '0;
            res_data_q     <= '0;
            res_error_q    <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            res_valid_q    <= pop && (fifo_gen_q[rd_q] == generation);
            protocol_err_q <= protocol_err_q | stray;
            if (pop) begin
                res_id_q    <= fifo_id_q[rd_q];
                res_data_q  <= mem_res_data;
                res_error_q <= mem_res_error;
            end
        end
    end

    assign res_valid    = res_valid_q;
    assign res_id       = res_id_q;
    assign res_data     = res_data_q;
    assign res_error    = res_error_q;
    assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_pw_mem_responder.sv
// Bench for pw_mem_responder: a vector table for arbitration/backpressure and
// hand-written sequences, with a response scoreboard fed as memory data is driven.
module tb_pw_mem_responder;

    localparam int NUM_PW  = 2;
    localparam int PADDR_W = 56;
    localparam int DEPTH   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [PADDR_W-1:0] req_paddr      [NUM_PW];
    logic [31:0]        req_generation [NUM_PW];
    logic [1:0]         req_accepted;
    logic               noroom;
    logic               res_valid;
    logic [0:0]         res_id;
    logic [63:0]        res_data;
    logic               res_error;
    logic [31:0]        generation = '0;
    logic               mem_req_valid;
    logic [PADDR_W-1:0] mem_req_addr;
    logic               mem_req_ready = 1'b0;
    logic               mem_res_valid = 1'b0;
    logic [63:0]        mem_res_data = '0;
    logic               mem_res_error = 1'b0;
    logic               protocol_err;

    pw_mem_responder #(.NUM_PW(NUM_PW), .PADDR_W(PADDR_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_paddr      (req_paddr),
        .req_generation (req_generation),
        .req_accepted   (req_accepted),
        .noroom         (noroom),
        .res_valid      (res_valid),
        .res_id         (res_id),
        .res_data       (res_data),
        .res_error      (res_error),
        .generation     (generation),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_res_valid  (mem_res_valid),
        .mem_res_data   (mem_res_data),
        .mem_res_error  (mem_res_error),
        .protocol_err   (protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id;
        logic [31:0] gen;
    } pend_t;

    typedef struct {
        logic        v;
        logic        id;
        logic [63:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic [1:0] rv;
        logic       rdy;
        logic [1:0] exp_acc;
        logic       exp_nr;
        logic       exp_mrv;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    pend_t pend[$];
    exp_t  exp_q[$];
    int    m_count = 0;
    int    m_rr = 0;
    logic  m_perr = 1'b0;
    logic  res_due = 1'b0;
    logic  [1:0] last_acc;
    logic  last_nr, last_mrv;

    logic [PADDR_W-1:0] nx_paddr [NUM_PW];
    logic [31:0]        nx_gen   [NUM_PW];
    logic [31:0]        nx_generation;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic check_res();
        exp_t e;
        if (res_due) begin
            e = exp_q.pop_front();
            chk("res_valid", 64'(res_valid), 64'(e.v));
            chk("res_id", 64'(res_id), 64'(e.id));
            chk("res_data", res_data, e.d);
            chk("res_error", 64'(res_error), 64'(e.e));
            $display("resp id=%0d valid=%0b data=%h err=%0b", res_id, res_valid, res_data, res_error);
        end else begin
            chk("res_valid_idle", 64'(res_valid), 64'd0);
        end
        chk("protocol_err", 64'(protocol_err), 64'(m_perr));
    endtask

    // One clock cycle: check last cycle's registered outputs, drive, then check
    // combinational outputs and update the scoreboard.
    task automatic step(input logic [1:0] rv, input logic rdy, input logic mrv,
                        input logic [63:0] mdat, input logic merr);
        logic       e_nr, e_mrv;
        logic [1:0] e_acc;
        int         w;
        pend_t      p;
        exp_t       e;
        @(negedge clock);
        check_res();
        req_valid      = rv;
        req_paddr      = nx_paddr;
        req_generation = nx_gen;
        generation     = nx_generation;
        mem_req_ready  = rdy;
        mem_res_valid  = mrv;
        mem_res_data   = mdat;
        mem_res_error  = merr;
        #1;
        e_nr  = (m_count == DEPTH);
        e_mrv = (rv != 2'b00) && !e_nr;
        w     = rv[m_rr] ? m_rr : 1 - m_rr;
        e_acc = (e_mrv && rdy) ? (2'b01 << w) : 2'b00;
        last_acc = req_accepted;
        last_nr  = noroom;
        last_mrv = mem_req_valid;
        chk("noroom", 64'(noroom), 64'(e_nr));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mrv));
        chk("req_accepted", 64'(req_accepted), 64'(e_acc));
        if (e_mrv) begin
            chk("mem_req_addr", 64'(mem_req_addr), 64'(nx_paddr[w] & ~56'h7));
        end
        res_due = 1'b0;
        if (mrv) begin
            if (pend.size() > 0) begin
                p    = pend.pop_front();
                e.v  = (p.gen == nx_generation);
                e.id = p.id;
                e.d  = mdat;
                e.e  = merr;
                exp_q.push_back(e);
                res_due = 1'b1;
                m_count--;
            end else begin
                m_perr = 1'b1;
            end
        end
        if (e_acc != 2'b00) begin
            p.id  = (w == 1);
            p.gen = nx_gen[w];
            pend.push_back(p);
            m_count++;
            m_rr = 1 - w;
            $display("req  id=%0d addr=%h gen=%0d", w, mem_req_addr, nx_gen[w]);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset         = 1'b1;
        req_valid     = 2'b01;
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b0;
        #1;
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_id", 64'(res_id), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_res_error", 64'(res_error), 64'd0);
        chk("rst_protocol_err", 64'(protocol_err), 64'd0);
        chk("rst_noroom", 64'(noroom), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd1);
        req_valid = 2'b00;
        pend.delete();
        exp_q.delete();
        m_count = 0;
        m_rr    = 0;
        m_perr  = 1'b0;
        res_due = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        $display("reset done");
    endtask

    vec_t vecs[8];

    initial begin
        nx_paddr[0] = 56'h0000_1000_0010;
        nx_paddr[1] = 56'h0000_2000_002F;
        nx_gen[0] = 32'd5;
        nx_gen[1] = 32'd5;
        nx_generation = 32'd5;
        req_paddr = nx_paddr;
        req_generation = nx_gen;

        // Arbitration and fill-up from reset (rr at 0, FIFO empty, no responses).
        vecs[0] = '{rv: 2'b00, rdy: 1'b1, exp_acc: 2'b00, exp_nr: 1'b0, exp_mrv: 1'b0};
        vecs[1] = '{rv: 2'b11, rdy: 1'b0, exp_acc: 2'b00, exp_nr: 1'b0, exp_mrv: 1'b1};
        vecs[2] = '{rv: 2'b10, rdy: 1'b1, exp_acc: 2'b10, exp_nr: 1'b0, exp_mrv: 1'b1};
        vecs[3] = '{rv: 2'b11, rdy: 1'b1, exp_acc: 2'b01, exp_nr: 1'b0, exp_mrv: 1'b1};
        vecs[4] = '{rv: 2'b11, rdy: 1'b1, exp_acc: 2'b10, exp_nr: 1'b0, exp_mrv: 1'b1};
        vecs[5] = '{rv: 2'b01, rdy: 1'b1, exp_acc: 2'b01, exp_nr: 1'b0, exp_mrv: 1'b1};
        vecs[6] = '{rv: 2'b11, rdy: 1'b1, exp_acc: 2'b00, exp_nr: 1'b1, exp_mrv: 1'b0};
        vecs[7] = '{rv: 2'b00, rdy: 1'b0, exp_acc: 2'b00, exp_nr: 1'b1, exp_mrv: 1'b0};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rv, vecs[i].rdy, 1'b0, 64'd0, 1'b0);
            chk("vec_acc", 64'(last_acc), 64'(vecs[i].exp_acc));
            chk("vec_noroom", 64'(last_nr), 64'(vecs[i].exp_nr));
            chk("vec_mrv", 64'(last_mrv), 64'(vecs[i].exp_mrv));
        end

        // Full FIFO: a pop does not make room in its own cycle, only in the next.
        step(2'b11, 1'b1, 1'b1, 64'h1111_0000_0000_0001, 1'b0);
        chk("full_no_push_on_pop", 64'(last_acc), 64'd0);
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        chk("full_room_next", 64'(last_nr), 64'd0);
        chk("full_fifth_acc", 64'(last_acc), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 1'b0, 1'b1, 64'h2222_0000_0000_0000 + 64'(i), (i == 2));
        end
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);

        // Single request from PW1, memory answers two cycles later.
        nx_paddr[1] = 56'h0000_8000_1008;
        step(2'b10, 1'b1, 1'b0, 64'd0, 1'b0);
        chk("single_acc", 64'(last_acc), 64'(2'b10));
        chk("single_addr", 64'(mem_req_addr), 64'h0000_0000_8000_1008);
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);
        step(2'b00, 1'b0, 1'b1, 64'h0000_0000_2000_0401, 1'b0);
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("single_res_valid", 64'(res_valid), 64'd1);
        chk("single_res_id", 64'(res_id), 64'd1);
        chk("single_res_data", res_data, 64'h0000_0000_2000_0401);

        // Generation drop: two requests at gen 7, live generation moves to 8.
        nx_gen[0] = 32'd7;
        nx_gen[1] = 32'd7;
        nx_generation = 32'd7;
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        nx_generation = 32'd8;
        step(2'b00, 1'b0, 1'b1, 64'h7777_0000_0000_0001, 1'b0);
        step(2'b00, 1'b0, 1'b1, 64'h7777_0000_0000_0002, 1'b0);
        chk("gen_drop_valid", 64'(res_valid), 64'd0);
        nx_gen[0] = 32'd8;
        nx_gen[1] = 32'd8;
        step(2'b01, 1'b1, 1'b0, 64'd0, 1'b0);
        step(2'b00, 1'b0, 1'b1, 64'h8888_0000_0000_0008, 1'b0);
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("gen_new_valid", 64'(res_valid), 64'd1);

        // Pointer wrap: simultaneous push and pop at count 2 for 10 cycles.
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(2'b11, 1'b1, 1'b1, 64'h5A5A_0000_0000_0000 + 64'(i), 1'b0);
            chk("wrap_noroom", 64'(last_nr), 64'd0);
        end
        step(2'b00, 1'b0, 1'b1, 64'h5A5A_0000_0000_00AA, 1'b0);
        step(2'b00, 1'b0, 1'b1, 64'h5A5A_0000_0000_00BB, 1'b1);

        // Reset with three entries outstanding, then a stray memory response.
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 64'd0, 1'b0);
        do_reset();
        step(2'b00, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);
        chk("stray_protocol_err", 64'(protocol_err), 64'd1);
        chk("stray_res_valid", 64'(res_valid), 64'd0);
        step(2'b00, 1'b0, 1'b0, 64'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
